// File: rtl/input_debouncer_pkg.sv
// Shared types and default parameter values for the input debouncer and its
// synchronizer.
//   state_t          - debounce FSM state encoding
//   DEF_*            - default parameter values for input_debouncer
//   reset_state()    - FSM state that matches a given reset level
package input_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_WAIT = 2'd3
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam logic        DEF_RESET_LEVEL     = 1'b0;
    localparam int unsigned DEF_GLITCH_W        = 8;

    // The FSM must start in the stable state that agrees with level_o.
    function automatic state_t reset_state(input logic lvl);
        return lvl ? ST_HIGH : ST_LOW;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit.
//   clk    - destination clock
//   reset  - asynchronous, active-high reset; all stages load RESET_VAL
//   d_i    - asynchronous input; sampled only by the first stage
//   q_o    - synchronized output (last stage)
module sync_chain import input_debouncer_pkg::*; #(
    parameter int unsigned STAGES    = DEF_SYNC_STAGES,
    parameter logic        RESET_VAL = DEF_RESET_LEVEL
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    // Bit 0 is the first (metastability-exposed) stage.
    logic [STAGES-1:0] stages_q;
    logic [STAGES-1:0] stages_d;

    always_comb begin
        stages_d = {stages_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages_q <= {STAGES{RESET_VAL}};
        end else begin
            stages_q <= stages_d;
        end
    end

    assign q_o = stages_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous input into a clean level with edge pulses.
//   clk           - clock for all state
//   reset         - asynchronous, active-high reset
//   raw_i         - raw bouncy input (switch or pin)
//   clr_glitch_i  - synchronous clear of glitch_cnt_o (wins over a glitch)
//   level_o       - debounced level
//   rise_o        - one-cycle pulse on an accepted 0->1 transition
//   fall_o        - one-cycle pulse on an accepted 1->0 transition
//   glitch_cnt_o  - saturating count of rejected transitions
module input_debouncer import input_debouncer_pkg::*; #(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic        RESET_LEVEL     = DEF_RESET_LEVEL,
    parameter int unsigned GLITCH_W        = DEF_GLITCH_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw_i,
    input  logic                clr_glitch_i,
    output logic                level_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic [GLITCH_W-1:0] glitch_cnt_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // cnt holds the number of new-value samples already seen, so the sample
    // that arrives while cnt == DEBOUNCE_CYCLES-1 is the accepting one.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic sync;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;

    logic glitch_ev;
    logic accept_rise;
    logic accept_fall;

    sync_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_LEVEL)
    ) u_sync_chain (
        .clk   (clk),
        .reset (reset),
        .d_i   (raw_i),
        .q_o   (sync)
    );

    // State register (FSM state, counter and registered outputs).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= reset_state(RESET_LEVEL);
            cnt_q    <= '0;
            level_q  <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        glitch_ev   = 1'b0;
        accept_rise = 1'b0;
        accept_fall = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (sync) begin
                    state_d = ST_RISE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RISE_WAIT: begin
                if (!sync) begin
                    state_d   = ST_LOW;
                    cnt_d     = '0;
                    glitch_ev = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_HIGH;
                    cnt_d       = '0;
                    accept_rise = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync) begin
                    state_d = ST_FALL_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_FALL_WAIT: begin
                if (sync) begin
                    state_d   = ST_HIGH;
                    cnt_d     = '0;
                    glitch_ev = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_LOW;
                    cnt_d       = '0;
                    accept_fall = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = reset_state(RESET_LEVEL);
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        level_d = level_q;
        if (accept_rise) begin
            level_d = 1'b1;
        end else if (accept_fall) begin
            level_d = 1'b0;
        end
        rise_d = accept_rise;
        fall_d = accept_fall;

        glitch_d = glitch_q;
        if (clr_glitch_i) begin
            glitch_d = '0;
        end else if (glitch_ev && (glitch_q != {GLITCH_W{1'b1}})) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    assign level_o      = level_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign glitch_cnt_o = glitch_q;

endmodule
